// File: rtl/alu_pkg.sv
// Shared constants for the ALU command path: opcodes, data width and sequencer states.
package alu_pkg;

   localparam int DATA_W = 8;

   localparam logic [2:0] OP_ADD  = 3'b000;
   localparam logic [2:0] OP_SUB  = 3'b001;
   localparam logic [2:0] OP_AND  = 3'b010;
   localparam logic [2:0] OP_OR   = 3'b011;
   localparam logic [2:0] OP_XOR  = 3'b100;
   localparam logic [2:0] OP_NAND = 3'b101;
   localparam logic [2:0] OP_NOR  = 3'b110;
   localparam logic [2:0] OP_XNOR = 3'b111;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_GET_A = 3'd1,
      ST_GET_B = 3'd2,
      ST_EXEC  = 3'd3,
      ST_OUT   = 3'd4
   } state_t;

endpackage

// File: rtl/ALU.sv
// Combinational 8-bit ALU; carry is always the unsigned add carry regardless of opcode.
module ALU
   import alu_pkg::*;
(
   input  logic [2:0]        op,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   output logic [DATA_W-1:0] result,
   output logic              carry
);

   logic [DATA_W:0] sum;

   assign sum   = {1'b0, a} + {1'b0, b};
   assign carry = sum[DATA_W];

   always_comb begin
      result = '0;
      case (op)
         OP_ADD:  result = sum[DATA_W-1:0];
         OP_SUB:  result = a - b;
         OP_AND:  result = a & b;
         OP_OR:   result = a | b;
         OP_XOR:  result = a ^ b;
         OP_NAND: result = ~(a & b);
         OP_NOR:  result = ~(a | b);
         OP_XNOR: result = ~(a ^ b);
         default: result = '0;
      endcase
   end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Collects opcode/a/b bytes, runs one ALU operation and holds the result until taken.
//
// state  | meaning
// IDLE   | waiting for opcode byte
// GET_A  | waiting for operand a
// GET_B  | waiting for operand b
// EXEC   | one cycle: ALU result registered
// OUT    | result valid, held until res_ready
module alu_cmd_sequencer
   import alu_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [DATA_W-1:0] res_data,
   output logic              res_carry,
   output logic              res_zero,
   output logic              res_valid,
   input  logic              res_ready,
   output logic              busy
);

   state_t            state;
   state_t            state_nxt;
   logic [2:0]        op;
   logic [DATA_W-1:0] opnd_a;
   logic [DATA_W-1:0] opnd_b;
   logic [DATA_W-1:0] alu_result;
   logic              alu_carry;
   logic              in_xfer;
   logic              in_data_unused;

   // only the low three bits of the opcode byte carry meaning
   assign in_data_unused = ^in_data[DATA_W-1:3];

   ALU u_alu (
      .op     (op),
      .a      (opnd_a),
      .b      (opnd_b),
      .result (alu_result),
      .carry  (alu_carry)
   );

   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      res_valid = 1'b0;
      busy      = 1'b1;
      case (state)
         ST_IDLE: begin
            in_ready = 1'b1;
            busy     = 1'b0;
            if (in_valid) state_nxt = ST_GET_A;
         end
         ST_GET_A: begin
            in_ready = 1'b1;
            if (in_valid) state_nxt = ST_GET_B;
         end
         ST_GET_B: begin
            in_ready = 1'b1;
            if (in_valid) state_nxt = ST_EXEC;
         end
         ST_EXEC: state_nxt = ST_OUT;
         ST_OUT: begin
            res_valid = 1'b1;
            if (res_ready) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   assign in_xfer = in_valid && in_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         op        <= '0;
         opnd_a    <= '0;
         opnd_b    <= '0;
         res_data  <= '0;
         res_carry <= 1'b0;
         res_zero  <= 1'b0;
      end else begin
         if (in_xfer && state == ST_IDLE)  op     <= in_data[2:0];
         if (in_xfer && state == ST_GET_A) opnd_a <= in_data;
         if (in_xfer && state == ST_GET_B) opnd_b <= in_data;
         if (state == ST_EXEC) begin
            res_data  <= alu_result;
            res_carry <= alu_carry;
            res_zero  <= (alu_result == '0);
         end
      end
   end

endmodule
